spi_reg_ctrl: RTL
=================

# spi_reg_ctrl

SPI-slave register controller for the onboarding PWM tile. It receives 16-bit write frames from an external SPI master on the dedicated input pins and decodes them into five 8-bit configuration registers. Those registers drive the output-enable and PWM-enable masks of the 16 PWM/static output lanes and the shared duty cycle. It sits between `ui_in[2:0]` and the PWM peripheral inside the top-level `tt_um_` wrapper.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth for the asynchronous SPI inputs; minimum 2.
- `MAX_ADDR`, default 7'h04: highest valid register address.

- `clk` input 1: system clock; all logic on its rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `sclk` input 1: SPI clock (`ui_in[0]`), asynchronous to `clk`.
- `copi` input 1: SPI data in (`ui_in[1]`), asynchronous.
- `ncs` input 1: SPI chip select, active low (`ui_in[2]`), asynchronous.
- `en_reg_out_7_0` output 8: register at address 0x00.
- `en_reg_out_15_8` output 8: register at address 0x01.
- `en_reg_pwm_7_0` output 8: register at address 0x02.
- `en_reg_pwm_15_8` output 8: register at address 0x03.
- `pwm_duty_cycle` output 8: register at address 0x04.
- `wr_strobe` output 1: one-cycle pulse when a register commit occurs.

## Operation
**Input conditioning**
- Each SPI input passes through a `SYNC_STAGES` flop chain plus one history flop for edge detection.
- Reset values: the `ncs` chain resets to 1; the `sclk` and `copi` chains reset to 0.

**Frame format:** SPI mode 0, MSB first, 16 bits.
- bit 15: R/W (1 = write).
- bits 14:8: address.
- bits 7:0: data.

**States:** `IDLE`, `SHIFT`.
- `IDLE`: waits for a synchronized `ncs` falling edge, then clears the 16-bit shift register and the 5-bit bit counter and goes to `SHIFT`.
- `SHIFT`, on each synchronized `sclk` rising edge:
  - shift the synchronized `copi` into the LSB;
  - increment the bit counter, saturating at 17.
- `SHIFT`, on a synchronized `ncs` rising edge:
  - commit if and only if counter == 16, bit 15 == 1 and address <= `MAX_ADDR`;
  - on commit, write data to the addressed register and pulse `wr_strobe`;
  - return to `IDLE` whether or not the frame committed.

**Discarded frames:** read frames (bit 15 = 0), out-of-range addresses, short frames (<16 bits) and long frames (>16 bits) are discarded silently. Registers keep their previous values.

**Other rules**
- `sclk` edges while `ncs` is high are ignored.
- Coincident `ncs` rise and `sclk` rise in the same cycle: the `sclk` edge is taken first and included in the count, then the `ncs` rise is evaluated.
- Reset mid-frame:
  - all registers clear, `wr_strobe` = 0, state goes to `IDLE`;
  - if `ncs` is still low at reset release, the reset value of 1 makes the synchronizer see a fresh falling edge;
  - the remainder of the old frame is therefore counted from zero and rejected unless exactly 16 further bits arrive.

## Timing
- Reset value of every output register is 8'h00; `wr_strobe` resets to 0.
- Commit latency: the register update and `wr_strobe` are visible `SYNC_STAGES`+2 `clk` rising edges after the pin-level `ncs` rising edge (4 cycles at the default).
- `wr_strobe` stays high for exactly one cycle.
- Register outputs update only on a commit and are otherwise stable.
- SPI rate limits:
  - each `sclk` high and low phase ≥ `SYNC_STAGES`+1 `clk` periods;
  - `ncs` high between frames ≥ `SYNC_STAGES`+1 `clk` periods.
  - Example: at 10 MHz `clk`, `sclk` ≤ 1 MHz.
- Back-to-back frames that meet the `ncs`-high minimum each commit independently.

## Structure
- Package `spi_reg_pkg` holds:
  - `FRAME_BITS` = 16;
  - address constants `ADDR_EN_OUT_LO`/`ADDR_EN_OUT_HI`/`ADDR_EN_PWM_LO`/`ADDR_EN_PWM_HI`/`ADDR_DUTY` (0x00–0x04);
  - the state enum `spi_state_t` { `IDLE`, `SHIFT` }.
- Sub-module `spi_sync_edge`, instantiated three times (one per SPI input):
  - parameters: `SYNC_STAGES`, reset value;
  - outputs: synchronized level, `rise` pulse, `fall` pulse.
- The register file and address decode stay in `spi_reg_ctrl`.

## Test plan
- Write frame 16'h80F0 (addr 0x00, data 0xF0) at 1 MHz `sclk` → `en_reg_out_7_0` = 0xF0 four cycles after `ncs` rises; one `wr_strobe`; all other registers stay 0x00.
- Frames 16'h8480 then 16'h8355 back-to-back → `pwm_duty_cycle` = 0x80, `en_reg_pwm_15_8` = 0x55; exactly two `wr_strobe` pulses.
- Read frame 16'h00AA, address-0x05 write 16'h85AA, and address-0x7F write → no register change, no `wr_strobe`.
- 15-bit frame, then 17-bit frame, both targeting addr 0x01 → `en_reg_out_15_8` stays 0x00; a following correct 16'h8133 sets it to 0x33.
- Preload all five registers to 0xFF; assert `rst_n` = 0 for 2 cycles mid-frame (after 8 bits), release with `ncs` still low, send the 8 remaining bits → all registers = 0x00 and the partial frame is rejected.
- `sclk` toggled 16 times with `ncs` high → no register change, state remains `IDLE`.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// ============================================================================
// spi_reg_pkg : shared constants and FSM state type for the SPI register slave
// Revision    : 1.0
// ============================================================================
`default_nettype none

package spi_reg_pkg;

  localparam int FRAME_BITS = 16;
  localparam int NUM_REGS   = 5;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ============================================================================
// spi_sync_edge : multi-flop synchronizer with registered rise/fall pulses
// Revision      : 1.0
// ============================================================================
`default_nettype none

module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise_q;
  logic                   fall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      hist_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      hist_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & hist_q;
    end
  end

  // Level is taken from the history flop so it stays aligned with the pulses.
  assign level_o = hist_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

`default_nettype wire

// File: rtl/spi_reg_ctrl.sv
// ============================================================================
// spi_reg_ctrl : SPI mode-0 write-only slave driving five 8-bit config regs
// Revision     : 1.0
// ============================================================================
`default_nettype none

module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe
);

  localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_SAT  = 5'(FRAME_BITS + 1);

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_copi_lvl, w_copi_rise, w_copi_fall;
  logic w_ncs_lvl,  w_ncs_rise,  w_ncs_fall;
  logic w_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .async_i(sclk),
    .level_o(w_sclk_lvl), .rise_o(w_sclk_rise), .fall_o(w_sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .async_i(copi),
    .level_o(w_copi_lvl), .rise_o(w_copi_rise), .fall_o(w_copi_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .async_i(ncs),
    .level_o(w_ncs_lvl), .rise_o(w_ncs_rise), .fall_o(w_ncs_fall)
  );

  assign w_unused = &{w_sclk_lvl, w_sclk_fall, w_copi_rise, w_copi_fall, w_ncs_lvl, 1'b0};

  spi_state_t            state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [4:0]            cnt_q, cnt_d;
  logic                  commit_d;
  logic                  wr_strobe_q;
  logic [7:0]            out_lo_q, out_hi_q, pwm_lo_q, pwm_hi_q, duty_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    commit_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_ncs_fall) begin
          shift_d = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (w_sclk_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], w_copi_lvl};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 5'd1;
        end
        // Evaluated on the post-shift values so a coincident final sclk edge counts.
        if (w_ncs_rise) begin
          commit_d = (cnt_d == CNT_FULL) && shift_d[15] && (shift_d[14:8] <= MAX_ADDR);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_strobe_q <= 1'b0;
      out_lo_q    <= 8'h00;
      out_hi_q    <= 8'h00;
      pwm_lo_q    <= 8'h00;
      pwm_hi_q    <= 8'h00;
      duty_q      <= 8'h00;
    end else begin
      wr_strobe_q <= commit_d;
      if (commit_d) begin
        case (shift_d[14:8])
          ADDR_EN_OUT_LO: out_lo_q <= shift_d[7:0];
          ADDR_EN_OUT_HI: out_hi_q <= shift_d[7:0];
          ADDR_EN_PWM_LO: pwm_lo_q <= shift_d[7:0];
          ADDR_EN_PWM_HI: pwm_hi_q <= shift_d[7:0];
          ADDR_DUTY:      duty_q   <= shift_d[7:0];
          default: ;
        endcase
      end
    end
  end

  assign en_reg_out_7_0  = out_lo_q;
  assign en_reg_out_15_8 = out_hi_q;
  assign en_reg_pwm_7_0  = pwm_lo_q;
  assign en_reg_pwm_15_8 = pwm_hi_q;
  assign pwm_duty_cycle  = duty_q;
  assign wr_strobe       = wr_strobe_q;

endmodule

`default_nettype wire
